// File: rtl/reaction_pkg.sv
// Shared constants for the F1 reaction round controller: default sizing,
// the "no best time yet" marker and the round state encoding.
package reaction_pkg;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_TIMEOUT_MS = 2000;

    // best_ms holds this value until the first valid reaction is measured
    localparam logic [DEF_CNT_W-1:0] BEST_NONE = '1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_ARM    = 3'd1;
    localparam state_t S_LIGHTS = 3'd2;
    localparam state_t S_TIMING = 3'd3;
    localparam state_t S_RESULT = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_JUMP   = 3'd6;
    localparam state_t S_TOUT   = 3'd7;

endpackage

// File: rtl/btn_sync_edge.sv
// Brings the raw reaction button into the clk domain and turns each rising
// edge into a single-cycle press. The press appears three clocks after the
// button rises; holding the button produces no further presses.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;
    logic r_press;

    // two-flop synchroniser, delayed copy and registered rising-edge pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_press   <= r_sync2 & ~r_sync2_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Round controller for the F1 reaction game: triggers the light sequence,
// waits for lights out, counts ms until the player presses, and keeps the
// best time since reset.
//
// state  | meaning
// IDLE   | after reset, waiting for the first start
// ARM    | trigger sent, waiting for the lights to come on
// LIGHTS | lights lit, waiting for lights out
// TIMING | counting ms ticks until the press or timeout
// RESULT | one cycle: publish react_ms, update best_ms
// DONE   | valid result held, start begins a new round
// JUMP   | press before lights out, start begins a new round
// TOUT   | no press within TIMEOUT_MS, start begins a new round
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT_MS = DEF_TIMEOUT_MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             btn,
    input  logic             lights_on,
    input  logic             ms_tick,
    output logic             f1_trigger,
    output logic             busy,
    output logic [CNT_W-1:0] react_ms,
    output logic [CNT_W-1:0] best_ms,
    output logic             result_valid,
    output logic             jump_start,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] L_BEST_NONE = '1;
    localparam logic [CNT_W-1:0] L_TOUT      = CNT_W'(TIMEOUT_MS);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_react;
    logic [CNT_W-1:0] r_best;
    logic             r_trig;
    logic             r_lights_d;
    logic             w_press;
    logic             w_fall;

    btn_sync_edge u_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn),
        .o_press (w_press)
    );

    assign w_fall = r_lights_d & ~lights_on;

    // round sequencing, ms counting, result capture and best-time tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_react    <= '0;
            r_best     <= L_BEST_NONE;
            r_trig     <= 1'b0;
            r_lights_d <= 1'b0;
        end else begin
            r_trig     <= 1'b0;
            r_lights_d <= lights_on;
            case (r_state)
                S_IDLE, S_DONE, S_JUMP, S_TOUT: begin
                    if (start) begin
                        r_state <= S_ARM;
                        r_trig  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (w_press) begin
                        r_state <= S_JUMP;
                    end else if (lights_on) begin
                        r_state <= S_LIGHTS;
                    end
                end
                S_LIGHTS: begin
                    // a press on the very cycle the lights go out is still early
                    if (w_press) begin
                        r_state <= S_JUMP;
                    end else if (w_fall) begin
                        r_state <= S_TIMING;
                        r_count <= '0;
                    end
                end
                S_TIMING: begin
                    // press wins over a coincident tick, so that tick is not counted
                    if (w_press) begin
                        r_react <= r_count;
                        r_state <= S_RESULT;
                    end else if (ms_tick) begin
                        // the tick that brings the count to TIMEOUT_MS ends the round
                        if (r_count >= L_TOUT - 1'b1) begin
                            r_count <= L_TOUT;
                            r_state <= S_TOUT;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    if (r_react < r_best) begin
                        r_best <= r_react;
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign f1_trigger   = r_trig;
    assign busy         = (r_state == S_ARM) || (r_state == S_LIGHTS) || (r_state == S_TIMING);
    assign react_ms     = r_react;
    assign best_ms      = r_best;
    assign result_valid = (r_state == S_RESULT);
    assign jump_start   = (r_state == S_JUMP);
    assign timeout      = (r_state == S_TOUT);

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl. The reference model is the
// game rule itself: a valid round reports the number of ms ticks seen after
// lights out, and best is the minimum of all valid results since reset.
module tb_reaction_timer_ctrl;

    localparam int CNT_W = 16;
    localparam int TOUT  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic btn = 1'b0;
    logic lights_on = 1'b0;
    logic ms_tick = 1'b0;
    logic f1_trigger;
    logic busy;
    logic result_valid;
    logic jump_start;
    logic timeout;
    logic [CNT_W-1:0] react_ms;
    logic [CNT_W-1:0] best_ms;

    int n_cmp = 0;
    int n_bad = 0;
    int trig_cnt = 0;
    int rv_cnt = 0;
    int m_react = 0;
    int m_best = 32'h0000FFFF;

    reaction_timer_ctrl #(.CNT_W(CNT_W), .TIMEOUT_MS(TOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .btn          (btn),
        .lights_on    (lights_on),
        .ms_tick      (ms_tick),
        .f1_trigger   (f1_trigger),
        .busy         (busy),
        .react_ms     (react_ms),
        .best_ms      (best_ms),
        .result_valid (result_valid),
        .jump_start   (jump_start),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (f1_trigger) trig_cnt++;
            if (result_valid) rv_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1;
            @(negedge clk);
            ms_tick = 1'b0;
            cyc($urandom_range(0, 2));
        end
    endtask

    task automatic lights_cycle(input int on_cycles);
        cyc(3);
        lights_on = 1'b1;
        cyc(on_cycles);
        lights_on = 1'b0;
        cyc(2);
    endtask

    task automatic do_press(input int hold);
        btn = 1'b1;
        cyc(hold);
        btn = 1'b0;
        cyc(4);
    endtask

    task automatic model_result(input int n);
        m_react = n;
        if (n < m_best) m_best = n;
    endtask

    task automatic run_round(input int n);
        pulse_start();
        lights_cycle($urandom_range(20, 100));
        give_ticks(n);
        do_press(6);
        cyc(2);
        model_result(n);
    endtask

    task automatic test_reset();
        cyc(3);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (react_ms !== 16'd0) begin n_bad++; $display("FAIL reset_react: got %0d want 0", react_ms); end
        n_cmp++; if (best_ms !== 16'hFFFF) begin n_bad++; $display("FAIL reset_best: got %h want ffff", best_ms); end
        n_cmp++; if ({f1_trigger, result_valid, jump_start, timeout} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {f1_trigger, result_valid, jump_start, timeout}); end
        rst = 1'b1;
        cyc(3);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_nominal();
        int t0 = trig_cnt;
        int r0 = rv_cnt;
        pulse_start();
        cyc(2);
        n_cmp++; if (trig_cnt - t0 != 1) begin n_bad++; $display("FAIL nom_trigger: got %0d pulses want 1", trig_cnt - t0); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy_arm: got %b want 1", busy); end
        lights_on = 1'b1;
        cyc(100);
        lights_on = 1'b0;
        cyc(2);
        give_ticks(250);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy_timing: got %b want 1", busy); end
        do_press(6);
        cyc(2);
        model_result(250);
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL nom_react: got %0d want %0d", react_ms, m_react); end
        n_cmp++; if (best_ms !== CNT_W'(m_best)) begin n_bad++; $display("FAIL nom_best: got %0d want %0d", best_ms, m_best); end
        n_cmp++; if (rv_cnt - r0 != 1) begin n_bad++; $display("FAIL nom_valid: got %0d valid cycles want 1", rv_cnt - r0); end
        n_cmp++; if ({busy, jump_start, timeout} !== 3'b000) begin
            n_bad++; $display("FAIL nom_done_flags: got %b want 000", {busy, jump_start, timeout}); end
    endtask

    task automatic test_best();
        int lens[3] = '{300, 120, 120};
        for (int i = 0; i < 3; i++) begin
            int r0 = rv_cnt;
            run_round(lens[i]);
            n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL best_react[%0d]: got %0d want %0d", i, react_ms, m_react); end
            n_cmp++; if (best_ms !== CNT_W'(m_best)) begin n_bad++; $display("FAIL best_best[%0d]: got %0d want %0d", i, best_ms, m_best); end
            n_cmp++; if (rv_cnt - r0 != 1) begin n_bad++; $display("FAIL best_valid[%0d]: got %0d want 1", i, rv_cnt - r0); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            int n = $urandom_range(1, 600);
            run_round(n);
            n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL rand_react[%0d]: got %0d want %0d", i, react_ms, m_react); end
            n_cmp++; if (best_ms !== CNT_W'(m_best)) begin n_bad++; $display("FAIL rand_best[%0d]: got %0d want %0d", i, best_ms, m_best); end
        end
    endtask

    task automatic test_jump();
        int r0 = rv_cnt;
        int t1;
        int n;
        pulse_start();
        cyc(3);
        lights_on = 1'b1;
        cyc(10);
        btn = 1'b1;
        cyc(6);
        btn = 1'b0;
        cyc(4);
        lights_on = 1'b0;
        cyc(3);
        n_cmp++; if (jump_start !== 1'b1) begin n_bad++; $display("FAIL jump_flag: got %b want 1", jump_start); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL jump_busy: got %b want 0", busy); end
        n_cmp++; if (rv_cnt - r0 != 0) begin n_bad++; $display("FAIL jump_valid: got %0d want 0", rv_cnt - r0); end
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL jump_react: got %0d want %0d", react_ms, m_react); end
        t1 = trig_cnt;
        pulse_start();
        cyc(2);
        n_cmp++; if (jump_start !== 1'b0) begin n_bad++; $display("FAIL jump_clear: got %b want 0", jump_start); end
        pulse_start();
        cyc(1);
        pulse_start();
        cyc(2);
        n_cmp++; if (trig_cnt - t1 != 1) begin n_bad++; $display("FAIL jump_retrigger: got %0d pulses want 1", trig_cnt - t1); end
        lights_cycle(40);
        n = $urandom_range(50, 400);
        give_ticks(n);
        do_press(6);
        cyc(2);
        model_result(n);
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL jump_after_react: got %0d want %0d", react_ms, m_react); end
        n_cmp++; if (best_ms !== CNT_W'(m_best)) begin n_bad++; $display("FAIL jump_after_best: got %0d want %0d", best_ms, m_best); end
        r0 = rv_cnt;
        pulse_start();
        cyc(2);
        do_press(6);
        cyc(2);
        n_cmp++; if (jump_start !== 1'b1) begin n_bad++; $display("FAIL jump_arm_flag: got %b want 1", jump_start); end
        n_cmp++; if (rv_cnt - r0 != 0) begin n_bad++; $display("FAIL jump_arm_valid: got %0d want 0", rv_cnt - r0); end
    endtask

    task automatic test_timeout();
        int r0 = rv_cnt;
        int n;
        pulse_start();
        lights_cycle(50);
        give_ticks(TOUT - 1);
        n_cmp++; if ({timeout, busy} !== 2'b01) begin n_bad++; $display("FAIL tout_early: got timeout,busy=%b want 01", {timeout, busy}); end
        give_ticks(1);
        n_cmp++; if ({timeout, busy} !== 2'b10) begin n_bad++; $display("FAIL tout_flag: got timeout,busy=%b want 10", {timeout, busy}); end
        do_press(6);
        cyc(2);
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL tout_react: got %0d want %0d", react_ms, m_react); end
        n_cmp++; if (rv_cnt - r0 != 0) begin n_bad++; $display("FAIL tout_valid: got %0d want 0", rv_cnt - r0); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL tout_hold: got %b want 1", timeout); end
        pulse_start();
        cyc(2);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL tout_clear: got %b want 0", timeout); end
        lights_cycle(30);
        n = $urandom_range(100, 500);
        give_ticks(n);
        do_press(6);
        cyc(2);
        model_result(n);
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL tout_after_react: got %0d want %0d", react_ms, m_react); end
    endtask

    task automatic test_coincide();
        int t1;
        int r0;
        pulse_start();
        lights_cycle(60);
        give_ticks(40);
        t1 = trig_cnt;
        pulse_start();
        cyc(1);
        pulse_start();
        r0 = rv_cnt;
        btn = 1'b1;
        cyc(3);
        ms_tick = 1'b1;
        cyc(1);
        ms_tick = 1'b0;
        give_ticks(5);
        btn = 1'b0;
        cyc(4);
        model_result(40);
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL coin_react: got %0d want %0d", react_ms, m_react); end
        n_cmp++; if (best_ms !== CNT_W'(m_best)) begin n_bad++; $display("FAIL coin_best: got %0d want %0d", best_ms, m_best); end
        n_cmp++; if (trig_cnt - t1 != 0) begin n_bad++; $display("FAIL coin_busy_start: got %0d pulses want 0", trig_cnt - t1); end
        n_cmp++; if (rv_cnt - r0 != 1) begin n_bad++; $display("FAIL coin_held_btn: got %0d valid cycles want 1", rv_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        lights_cycle(30);
        give_ticks(20);
        #3 rst = 1'b0;
        #1;
        m_react = 0;
        m_best  = 32'h0000FFFF;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (react_ms !== CNT_W'(m_react)) begin n_bad++; $display("FAIL rmid_react: got %0d want 0", react_ms); end
        n_cmp++; if (best_ms !== CNT_W'(m_best)) begin n_bad++; $display("FAIL rmid_best: got %h want ffff", best_ms); end
        n_cmp++; if ({f1_trigger, result_valid, jump_start, timeout} !== 4'b0000) begin
            n_bad++; $display("FAIL rmid_flags: got %b want 0000", {f1_trigger, result_valid, jump_start, timeout}); end
        cyc(3);
        rst = 1'b1;
        give_ticks(5);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_idle: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_best();
        test_random();
        test_jump();
        test_timeout();
        test_coincide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Round controller for the F1 reaction game. Sequences one round: pulses the light-sequence FSM's trigger, watches the lights turn on and then go out, and measures player reaction in milliseconds from ms ticks. Detects jump starts and timeouts, and tracks the best time. Sits above the f1_fsm/delay/clktick/lfsr datapath in top: its lights_on input is the OR of dout, and its ms_tick input comes from a clktick configured for 1 ms.

Parameters:
CNT_W, 16, width of the reaction and best-time counters
TIMEOUT_MS, 2000, maximum counted ms before the round is declared a timeout (must be < 2^CNT_W - 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  player start request, 1-cycle pulse; ignored unless idle or in a terminal state
btn  in  1  raw reaction button, asynchronous to clk
lights_on  in  1  high while any F1 light is lit (OR of dout)
ms_tick  in  1  1-cycle enable, once per ms
f1_trigger  out  1  1-cycle pulse to f1_fsm trigger
busy  out  1  high in ARM, LIGHTS, TIMING
react_ms  out  CNT_W  last measured reaction time, held until the next valid result
best_ms  out  CNT_W  best (smallest) reaction since reset; all-ones = none
result_valid  out  1  1-cycle pulse when react_ms is updated
jump_start  out  1  level; high in JUMP state
timeout  out  1  level; high in TOUT state

Behaviour:
- Reset (rst=0, async): state=IDLE, react_ms=0, best_ms='1, count=0, all pulses and flags 0, synchroniser flops 0.
- btn passes through a 2-flop synchroniser and a rising-edge detector. press = 1 cycle, 3 clk after the btn rise (2 sync + 1 edge reg). A held btn gives only one press.
- States:
  - IDLE: start -> ARM; f1_trigger=1 in the same cycle (registered, so it appears the next cycle as a 1-cycle pulse).
  - ARM: wait for lights_on=1 -> LIGHTS. A press here -> JUMP.
  - LIGHTS: lights_on falls (1->0, registered edge) -> TIMING with count=0. A press while lights_on=1 -> JUMP.
  - TIMING: ms_tick increments count.
    - press -> RESULT; react_ms captures count. If press and ms_tick coincide, the tick is not counted.
    - count==TIMEOUT_MS on a ms_tick with no press -> TOUT; count saturates, no wrap.
  - RESULT (1 cycle): result_valid=1. best_ms <= react_ms if react_ms < best_ms (strict). Then -> DONE.
  - DONE / JUMP / TOUT: terminal. Hold outputs. start -> ARM with f1_trigger pulse, and jump_start/timeout clear.
- start while busy is ignored (no re-trigger).
- A press and a lights_on falling edge in the same LIGHTS cycle count as a jump start.
- react_ms is not modified by JUMP or TOUT.
- Async reset mid-round returns immediately to IDLE. best_ms is lost.

Decomposition:
- Package reaction_pkg: state enum (IDLE, ARM, LIGHTS, TIMING, RESULT, DONE, JUMP, TOUT), localparam BEST_NONE (all-ones of CNT_W), default TIMEOUT_MS.
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse, async active-low reset.

Test Plan:
- Reset: rst=0 mid-TIMING -> state IDLE, react_ms=0, best_ms=16'hFFFF, busy=0, all flags 0.
- Nominal round: start, lights_on high 100 cycles then low, 250 ms_ticks, then btn rise -> react_ms=250, 1-cycle result_valid, best_ms=250, busy=0 after RESULT.
- Best tracking: second round 300 ms -> react_ms=300, best_ms stays 250. Third round 120 ms -> best_ms=120. Equal 120 -> no change.
- Jump start: btn rises while lights_on=1 -> jump_start=1, no result_valid, react_ms unchanged. Next start clears jump_start and issues exactly one f1_trigger.
- Timeout: no btn for 2000 ms_ticks after lights out -> timeout=1 at the 2000th tick, react_ms unchanged.
- Coincidence and ignore: press in the same cycle as a ms_tick at count 40 -> react_ms=40. start pulses during TIMING produce no f1_trigger. Btn held high for 5 ms after the press produces one press only.
